// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered binary-to-one-hot decoder with a
// prescaled up/down scan sequencer and wrap detection.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   clear           sync return to IDLE (highest priority)
//   load, sel_in    capture sel_in as the current index
//   scan_en, dir    auto-step enable, direction (1 = up)
//   en              output enable (gates out only)
//   out             registered one-hot of idx, or zero
//   idx             current index
//   active          state is HOLD or SCAN
//   wrap            one-cycle pulse on wrap / turnaround
//
// Build option: define ONEHOT_SCAN_BOUNCE_EN to make the scan reverse at
// the end indices instead of wrapping; dir is then sampled only on load
// and on HOLD->SCAN entry.

module onehot_scan_decoder #(
    parameter int SEL_W    = 3,
    parameter int STEP_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [SEL_W-1:0]        sel_in,
    input  logic                    scan_en,
    input  logic                    dir,
    input  logic                    en,
    output logic [(1<<SEL_W)-1:0]   out,
    output logic [SEL_W-1:0]        idx,
    output logic                    active,
    output logic                    wrap
);

    localparam int OUT_W = 1 << SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(OUT_W - 1);
    localparam logic [SEL_W-1:0] IDX_MIN = '0;
    localparam logic [15:0] PRE_TC = 16'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [15:0]        pre_q, pre_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               active_q, active_d;
    logic               wrap_q, wrap_d;
    logic               step;
    logic               up;

`ifdef ONEHOT_SCAN_BOUNCE_EN
    // Latched direction; flips internally at each turnaround.
    logic               dir_q, dir_d;
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            pre_q    <= '0;
            out_q    <= '0;
            active_q <= 1'b0;
            wrap_q   <= 1'b0;
`ifdef ONEHOT_SCAN_BOUNCE_EN
            dir_q    <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pre_q    <= pre_d;
            out_q    <= out_d;
            active_q <= active_d;
            wrap_q   <= wrap_d;
`ifdef ONEHOT_SCAN_BOUNCE_EN
            dir_q    <= dir_d;
`endif
        end
    end

    // Next-state logic: clear > load > scan step.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pre_d   = pre_q;
        wrap_d  = 1'b0;
        step    = 1'b0;
`ifdef ONEHOT_SCAN_BOUNCE_EN
        dir_d   = dir_q;
        up      = dir_q;
`else
        up      = dir;
`endif

        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            pre_d   = '0;
        end else if (load) begin
            idx_d   = sel_in;
            pre_d   = '0;
            state_d = scan_en ? SCAN : HOLD;
`ifdef ONEHOT_SCAN_BOUNCE_EN
            dir_d   = dir;
`endif
        end else begin
            case (state_q)
                HOLD: begin
                    if (scan_en) begin
                        state_d = SCAN;
                        pre_d   = '0;
`ifdef ONEHOT_SCAN_BOUNCE_EN
                        dir_d   = dir;
`endif
                    end
                end
                SCAN: begin
                    if (!scan_en) begin
                        state_d = HOLD;
                        pre_d   = '0;
                    end else if (pre_q == PRE_TC) begin
                        pre_d = '0;
                        step  = 1'b1;
                    end else begin
                        pre_d = pre_q + 16'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (step) begin
`ifdef ONEHOT_SCAN_BOUNCE_EN
            // Reverse at the end index instead of wrapping.
            if (up) begin
                if (idx_q == IDX_MAX) begin
                    idx_d  = idx_q - 1'b1;
                    dir_d  = 1'b0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d  = idx_q + 1'b1;
                end
            end else begin
                if (idx_q == IDX_MIN) begin
                    idx_d  = idx_q + 1'b1;
                    dir_d  = 1'b1;
                    wrap_d = 1'b1;
                end else begin
                    idx_d  = idx_q - 1'b1;
                end
            end
`else
            // SEL_W-bit arithmetic gives the modulo wrap for free.
            if (up) begin
                idx_d  = idx_q + 1'b1;
                wrap_d = (idx_q == IDX_MAX);
            end else begin
                idx_d  = idx_q - 1'b1;
                wrap_d = (idx_q == IDX_MIN);
            end
`endif
        end
    end

    // Output logic, computed from next state so outputs are plain flops.
    always_comb begin
        active_d = (state_d != IDLE);
        out_d    = '0;
        if (active_d && en) begin
            out_d = OUT_W'(1) << idx_d;
        end
    end

    assign out    = out_q;
    assign idx    = idx_q;
    assign active = active_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb_onehot_scan_decoder: directed checks of onehot_scan_decoder with
// STEP_DIV=4 and STEP_DIV=1 instances driven from shared inputs.

module tb_onehot_scan_decoder;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       load;
    logic [2:0] sel_in;
    logic       scan_en;
    logic       dir;
    logic       en;

    logic [7:0] out4, out1;
    logic [2:0] idx4, idx1;
    logic       act4, act1;
    logic       wrap4, wrap1;

    int n_chk;
    int n_fail;

    onehot_scan_decoder #(.SEL_W(3), .STEP_DIV(4)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .load   (load),
        .sel_in (sel_in),
        .scan_en(scan_en),
        .dir    (dir),
        .en     (en),
        .out    (out4),
        .idx    (idx4),
        .active (act4),
        .wrap   (wrap4)
    );

    onehot_scan_decoder #(.SEL_W(3), .STEP_DIV(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .load   (load),
        .sel_in (sel_in),
        .scan_en(scan_en),
        .dir    (dir),
        .en     (en),
        .out    (out1),
        .idx    (idx1),
        .active (act1),
        .wrap   (wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_o;
        logic       exp_w;
        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        clear   = 1'b0;
        load    = 1'b0;
        sel_in  = 3'd0;
        scan_en = 1'b0;
        dir     = 1'b1;
        en      = 1'b1;
        step();
        step();
        check("rst_out", {24'd0, out4}, 32'h0);
        check("rst_idx", {29'd0, idx4}, 32'h0);
        check("rst_act", {31'd0, act4}, 32'h0);
        check("rst_wrap", {31'd0, wrap4}, 32'h0);
        rst = 1'b0;

        // Load index 5.
        load   = 1'b1;
        sel_in = 3'd5;
        step();
        check("ld5_out", {24'd0, out4}, 32'h20);
        check("ld5_idx", {29'd0, idx4}, 32'd5);
        check("ld5_act", {31'd0, act4}, 32'h1);
        check("ld5_wrap", {31'd0, wrap4}, 32'h0);
        load = 1'b0;

        // STEP_DIV=4 up scan from 6.
        clear = 1'b1;
        step();
        clear   = 1'b0;
        load    = 1'b1;
        sel_in  = 3'd6;
        scan_en = 1'b1;
        dir     = 1'b1;
        step();
        load = 1'b0;
        check("s4_c0", {24'd0, out4}, 32'h40);
        for (int i = 1; i < 4; i++) begin
            step();
            check("s4_hold6", {24'd0, out4}, 32'h40);
            check("s4_nowrap", {31'd0, wrap4}, 32'h0);
        end
        step();
        check("s4_7", {24'd0, out4}, 32'h80);
        check("s4_7wrap", {31'd0, wrap4}, 32'h0);
        for (int i = 1; i < 4; i++) begin
            step();
            check("s4_hold7", {24'd0, out4}, 32'h80);
        end
        step();
`ifdef ONEHOT_SCAN_BOUNCE_EN
        exp_o = 8'h40;
`else
        exp_o = 8'h01;
`endif
        check("s4_wrapval", {24'd0, out4}, {24'd0, exp_o});
        check("s4_wrap", {31'd0, wrap4}, 32'h1);
        step();
        check("s4_wrapone", {31'd0, wrap4}, 32'h0);

        // Scan stops in HOLD when scan_en drops.
        load    = 1'b1;
        sel_in  = 3'd2;
        scan_en = 1'b1;
        step();
        load    = 1'b0;
        scan_en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("hold_idx", {29'd0, idx4}, 32'd2);
        check("hold_act", {31'd0, act4}, 32'h1);

`ifndef ONEHOT_SCAN_BOUNCE_EN
        // STEP_DIV=1 down scan from 0.
        load    = 1'b1;
        sel_in  = 3'd0;
        scan_en = 1'b1;
        dir     = 1'b0;
        step();
        load = 1'b0;
        check("s1_0", {24'd0, out1}, 32'h01);
        step();
        check("s1_7", {24'd0, out1}, 32'h80);
        check("s1_7wrap", {31'd0, wrap1}, 32'h1);
        step();
        check("s1_6", {24'd0, out1}, 32'h40);
        check("s1_6wrap", {31'd0, wrap1}, 32'h0);
`else
        // Bounce: STEP_DIV=1 up from 6 turns around at 7.
        load    = 1'b1;
        sel_in  = 3'd6;
        scan_en = 1'b1;
        dir     = 1'b1;
        step();
        load = 1'b0;
        dir  = 1'b0;
        check("bn_6", {29'd0, idx1}, 32'd6);
        step();
        check("bn_7", {29'd0, idx1}, 32'd7);
        step();
        check("bn_6b", {29'd0, idx1}, 32'd6);
        check("bn_wrap", {31'd0, wrap1}, 32'h1);
        step();
        check("bn_5", {29'd0, idx1}, 32'd5);
        check("bn_5wrap", {31'd0, wrap1}, 32'h0);
`endif
        scan_en = 1'b0;
        dir     = 1'b1;

        // clear beats load; en gates output only.
        clear  = 1'b1;
        load   = 1'b1;
        sel_in = 3'd4;
        step();
        check("cl_out", {24'd0, out4}, 32'h0);
        check("cl_idx", {29'd0, idx4}, 32'h0);
        check("cl_act", {31'd0, act4}, 32'h0);
        clear  = 1'b0;
        sel_in = 3'd3;
        en     = 1'b0;
        step();
        load = 1'b0;
        check("en0_out", {24'd0, out4}, 32'h0);
        check("en0_idx", {29'd0, idx4}, 32'd3);
        check("en0_act", {31'd0, act4}, 32'h1);
        en = 1'b1;
        step();
        check("en1_out", {24'd0, out4}, 32'h08);

        // Async reset mid-scan.
        load    = 1'b1;
        sel_in  = 3'd4;
        scan_en = 1'b1;
        step();
        load = 1'b0;
        step();
        check("pre_rst_idx", {29'd0, idx1}, 32'd5);
        #2 rst = 1'b1;
        #1;
        check("arst_out", {24'd0, out1}, 32'h0);
        check("arst_idx", {29'd0, idx1}, 32'h0);
        check("arst_act", {31'd0, act1}, 32'h0);
        check("arst_wrap", {31'd0, wrap1}, 32'h0);
        step();
        rst = 1'b0;
        step();
        step();
        check("idle_act", {31'd0, act1}, 32'h0);
        check("idle_idx", {29'd0, idx1}, 32'h0);
        exp_w = 1'b0;
        check("idle_out", {24'd0, out1}, {31'd0, exp_w});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
